// File: rtl/mvau_inp_buf_ctrl_pkg.sv
// Shared definitions for the MVAU input-buffer sequencer and its fold counter.
package mvau_inp_buf_ctrl_pkg;

    // WR: first pass, consuming input beats; RD: replay passes from the buffer.
    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } inp_buf_state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_inp_buf_ctrl_fold_cnt.sv
// Two-level wrap counter: inner synapse fold (SF) carrying into outer neuron fold (NF).
module mvau_fold_cnt
    import mvau_inp_buf_ctrl_pkg::*;
#(
    parameter  int SF   = 16,
    parameter  int NF   = 4,
    localparam int SF_W = cnt_width(SF),
    localparam int NF_W = cnt_width(NF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [SF_W-1:0] sf_cnt,
    output logic [NF_W-1:0] nf_cnt,
    output logic            sf_last_c,
    output logic            nf_last_c
);

    localparam logic [SF_W-1:0] SF_MAX = SF_W'(SF - 1);
    localparam logic [NF_W-1:0] NF_MAX = NF_W'(NF - 1);

    assign sf_last_c = (sf_cnt == SF_MAX);
    assign nf_last_c = (nf_cnt == NF_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sf_cnt <= '0;
            nf_cnt <= '0;
        end else if (en) begin
            if (sf_last_c) begin
                sf_cnt <= '0;
                nf_cnt <= nf_last_c ? '0 : nf_cnt + 1'b1;
            end else begin
                sf_cnt <= sf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// Sequencer for the MVAU stream input buffer: write-through first pass, NF-1 replays,
// and a 1-deep valid/ready output stage carrying the fold markers.
module mvau_inp_buf_ctrl
    import mvau_inp_buf_ctrl_pkg::*;
#(
    parameter int SF       = 16,
    parameter int NF       = 4,
    parameter int BUF_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_v,
    output logic                in_rdy,
    output logic                buf_wr_en,
    output logic                buf_rd_en,
    output logic [BUF_ADDR-1:0] buf_addr,
    output logic                out_v,
    input  logic                out_rdy,
    output logic                sf_last,
    output logic                nf_last,
    output logic                busy
);

    localparam int SF_W = cnt_width(SF);
    localparam int NF_W = cnt_width(NF);

    inp_buf_state_t      state, next_state;
    logic [SF_W-1:0]     sf_cnt;
    logic [NF_W-1:0]     nf_cnt;
    logic                sf_last_c, nf_last_c;
    logic                issue_ok, issue;
    logic [BUF_ADDR-1:0] last_addr;

    mvau_fold_cnt #(
        .SF (SF),
        .NF (NF)
    ) u_fold_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (issue),
        .sf_cnt    (sf_cnt),
        .nf_cnt    (nf_cnt),
        .sf_last_c (sf_last_c),
        .nf_last_c (nf_last_c)
    );

    assign issue_ok = !out_v || out_rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= WR;
        else     state <= next_state;
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        next_state = state;
        in_rdy     = 1'b0;
        issue      = 1'b0;
        buf_wr_en  = 1'b0;
        buf_rd_en  = 1'b0;
        buf_addr   = last_addr;
        if (!rst) begin
            case (state)
                WR: begin
                    in_rdy = issue_ok;
                    issue  = in_v && issue_ok;
                    if (issue && sf_last_c && NF > 1) next_state = RD;
                end
                RD: begin
                    issue = issue_ok;
                    if (issue && sf_last_c && nf_last_c) next_state = WR;
                end
                default: next_state = WR;
            endcase
            if (issue) begin
                buf_wr_en = (state == WR);
                buf_rd_en = (state == RD);
                buf_addr  = BUF_ADDR'(sf_cnt);
            end else begin
                // Re-read the held entry so the buffer output stays stable under backpressure.
                buf_rd_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
            out_v     <= 1'b0;
            sf_last   <= 1'b0;
            nf_last   <= 1'b0;
        end else begin
            if (issue) begin
                last_addr <= BUF_ADDR'(sf_cnt);
                sf_last   <= sf_last_c;
                nf_last   <= nf_last_c;
                out_v     <= 1'b1;
            end else if (out_rdy) begin
                out_v     <= 1'b0;
            end
        end
    end

    assign busy = (sf_cnt != '0) || (nf_cnt != '0) || out_v;

endmodule
